// File: rtl/fb_pkg.sv
// Shared constants and types for the paint frame-buffer access scheduler.
package fb_pkg;

    localparam int FB_ADDR_W = 15;
    localparam int FB_DATA_W = 8;
    localparam int FB_DEPTH  = 19200;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    // RGB 3-3-2 reference colours
    localparam logic [FB_DATA_W-1:0] BLACK = 8'h00;
    localparam logic [FB_DATA_W-1:0] WHITE = 8'hFF;

endpackage

// File: rtl/fb_access_sched_if.sv
// Client and RAM signals of the frame-buffer scheduler; slave is the scheduler side.
interface fb_access_sched_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_valid;
    logic              pnt_req;
    logic [ADDR_W-1:0] pnt_addr;
    logic [DATA_W-1:0] pnt_data;
    logic              pnt_gnt;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output vga_req, vga_addr, pnt_req, pnt_addr, pnt_data,
               clr_start, clr_color, ram_rdata,
        input  vga_data, vga_valid, pnt_gnt, clr_busy,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  vga_req, vga_addr, pnt_req, pnt_addr, pnt_data,
               clr_start, clr_color, ram_rdata,
        output vga_data, vga_valid, pnt_gnt, clr_busy,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/fb_clear_seq.sv
// Full-screen clear sequencer: walks 0..DEPTH-1 once per start, one address per advance.
module fb_clear_seq
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int DEPTH  = FB_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] color_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic [DATA_W-1:0] color_o,
    output logic              busy_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= DATA_W'(BLACK);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
        end
    end

    // NOTE: every next-state value is defaulted first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    color_d = color_i;
                end
            end
            CLEAR: begin
                // start_i is deliberately ignored here: no restart, no colour change
                if (advance_i) begin
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_o   = cnt_q;
    assign color_o = color_q;
    assign busy_o  = (state_q == CLEAR);

endmodule

// File: rtl/fb_access_sched.sv
// Single-port frame-buffer arbiter: VGA reads first, then clear writes, then brush writes.
module fb_access_sched
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int DEPTH  = FB_DEPTH,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fb_access_sched_if.slave     bus
);

    logic              clr_busy;
    logic              clr_advance;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] clr_color_q;
    logic              rd_grant;
    logic [RD_LAT-1:0] vld_q;

    fb_clear_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (bus.clr_start),
        .color_i   (bus.clr_color),
        .advance_i (clr_advance),
        .cnt_o     (clr_cnt),
        .color_o   (clr_color_q),
        .busy_o    (clr_busy)
    );

    // Gating on rst_n keeps the RAM quiet while reset is held, even with vga_req high.
    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.pnt_gnt   = 1'b0;
        clr_advance   = 1'b0;
        rd_grant      = 1'b0;
        if (rst_n) begin
            if (bus.vga_req) begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = bus.vga_addr;
                rd_grant     = 1'b1;
            end else if (clr_busy) begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = clr_cnt;
                bus.ram_wdata = clr_color_q;
                clr_advance   = 1'b1;
            end else if (bus.pnt_req && !bus.clr_start) begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = bus.pnt_addr;
                bus.ram_wdata = bus.pnt_data;
                bus.pnt_gnt   = 1'b1;
            end
        end
    end

    // NOTE: the valid pipe is reset so no phantom read returns after reset; RAM contents are not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_grant;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign bus.vga_valid = vld_q[RD_LAT-1];
    assign bus.vga_data  = bus.ram_rdata;
    assign bus.clr_busy  = clr_busy;

endmodule
